if_prefetch: RTL

//  Parametrised fetch unit replacing the pc_reg + if_id pair. Holds the fetch PC and issues

---
 rtl/if_prefetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: fetch unit that holds the PC, issues pipelined requests to a
// variable-latency instruction memory and queues the returned words for id.
// Optional feature macro: IF_PREFETCH_BYPASS_EN (same-cycle bypass when the queue is empty).
module if_prefetch #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       INST_W     = 32,
    parameter int unsigned       DEPTH      = 4,
    parameter int unsigned       MAX_OUT    = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_flag_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned FP_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [INST_W-1:0] INST_NOP = INST_W'(32'h0000_0013);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OUT_W-1:0]  out_q, out_d, drop_q, drop_d;
    logic [FP_W-1:0]   fl_rd_q, fl_rd_d, fl_wr_q, fl_wr_d;

    logic [INST_W-1:0] q_inst_q [DEPTH];
    logic [ADDR_W-1:0] q_addr_q [DEPTH];
    logic [ADDR_W-1:0] fl_addr_q [MAX_OUT];

    logic [SUM_W-1:0]  used_c;
    logic              fire_c, keep_c, head_valid_c, byp_c, pop_c, push_c;

    // Wrap an in-flight FIFO pointer; MAX_OUT need not be a power of two.
    function automatic logic [FP_W-1:0] fl_inc(input logic [FP_W-1:0] p);
        return (p == FP_W'(MAX_OUT - 1)) ? '0 : p + FP_W'(1);
    endfunction

    // Request issue, response classification and head presentation.
    always_comb begin
        imem_req_o   = 1'b0;
        imem_addr_o  = pc_q;
        inst_o       = INST_NOP;
        inst_addr_o  = '0;
        inst_valid_o = 1'b0;
        byp_c        = 1'b0;

        // Queue slots already promised to outstanding, non-dropped requests count as used.
        used_c = SUM_W'(count_q) + SUM_W'(out_q) - SUM_W'(drop_q);
        imem_req_o = !rst && !jump_flag_i && (used_c < SUM_W'(DEPTH))
                     && (out_q < OUT_W'(MAX_OUT));
        fire_c = imem_req_o && imem_gnt_i;

        keep_c       = !rst && imem_rvalid_i && !jump_flag_i && (drop_q == '0);
        head_valid_c = !rst && (count_q != '0);
`ifdef IF_PREFETCH_BYPASS_EN
        byp_c = keep_c && (count_q == '0);
`endif
        inst_valid_o = head_valid_c || byp_c;
        if (head_valid_c) begin
            inst_o      = q_inst_q[rd_ptr_q];
            inst_addr_o = q_addr_q[rd_ptr_q];
        end else if (byp_c) begin
            inst_o      = imem_rdata_i;
            inst_addr_o = fl_addr_q[fl_rd_q];
        end

        // A bypassed word that id takes immediately never enters the queue.
        pop_c  = head_valid_c && !hold_flag_i && !jump_flag_i;
        push_c = keep_c && !(byp_c && !hold_flag_i);
    end

    // Next-state for PC, queue pointers and request bookkeeping.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        out_d    = out_q + OUT_W'(fire_c) - OUT_W'(imem_rvalid_i);
        drop_d   = drop_q;
        fl_rd_d  = fl_rd_q;
        fl_wr_d  = fl_wr_q;

        if (jump_flag_i) begin
            // Everything still in flight belongs to the old stream.
            pc_d     = jump_addr_i;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            drop_d   = out_d;
            fl_rd_d  = '0;
            fl_wr_d  = '0;
        end else begin
            if (fire_c) begin
                pc_d    = pc_q + ADDR_W'(4);
                fl_wr_d = fl_inc(fl_wr_q);
            end
            if (imem_rvalid_i && (drop_q != '0)) begin
                drop_d = drop_q - OUT_W'(1);
            end
            if (keep_c) begin
                fl_rd_d = fl_inc(fl_rd_q);
            end
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_ADDR;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            fl_rd_q  <= '0;
            fl_wr_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            fl_rd_q  <= fl_rd_d;
            fl_wr_q  <= fl_wr_d;
        end
    end

    // Data storage; contents are only meaningful behind the valid pointers.
    always_ff @(posedge clk) begin
        if (push_c) begin
            q_inst_q[wr_ptr_q] <= imem_rdata_i;
            q_addr_q[wr_ptr_q] <= fl_addr_q[fl_rd_q];
        end
        if (fire_c) begin
            fl_addr_q[fl_wr_q] <= pc_q;
        end
    end

endmodule
